iir_cascade: RTL and testbench

- Parametrised, multi-channel cascade of first-order low-pass IIR stages with valid/ready handshaking at every stage.
- Sits between the SIPO deserializer and the PISO serializer of the audio path and replaces hand-instantiated chains of single iir instances.
- Adds generalised width, stage count and channel count, a runtime-selectable coefficient shift, a bypass mode and fractional state precision.

---
 rtl/iir_cascade.sv | 129 ++++++++++++
 tb/tb_iir_cascade.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_cascade.sv
// Multi-channel cascade of first-order low-pass IIR stages with per-stage valid/ready.
// Each beat carries its own shift and bypass mode down the pipeline.
module iir_cascade #(
  parameter int width_p       = 24,
  parameter int channels_p    = 2,
  parameter int stages_p      = 4,
  parameter int frac_p        = 6,
  parameter int shift_width_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [shift_width_p-1:0]       shift_i,
  input  logic                           bypass_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [channels_p*width_p-1:0]  data_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [channels_p*width_p-1:0]  data_o
);

  localparam int SW = width_p + frac_p;
  localparam int DW = channels_p * width_p;
  localparam int TW = channels_p * SW;

  logic [stages_p-1:0]      v_q, v_d;
  logic [stages_p-1:0]      byp_q, byp_d;
  logic [shift_width_p-1:0] k_q  [stages_p];
  logic [shift_width_p-1:0] k_d  [stages_p];
  logic [DW-1:0]            y_q  [stages_p];
  logic [DW-1:0]            y_d  [stages_p];
  logic [TW-1:0]            st_q [stages_p];
  logic [TW-1:0]            st_d [stages_p];

  logic [stages_p:0]        rdy;
  logic [stages_p-1:0]      in_v, in_byp, xfer;
  logic [DW-1:0]            in_data [stages_p];
  logic [shift_width_p-1:0] in_k    [stages_p];

  // Ready ripples back from the sink so a full pipeline still advances every cycle.
  always_comb begin : c_ready
    rdy = '0;
    rdy[stages_p] = ready_i;
    for (int i = 0; i < stages_p; i++) begin
      rdy[stages_p-1-i] = ~v_q[stages_p-1-i] | rdy[stages_p-i];
    end
  end

  always_comb begin : c_stage_in
    in_v       = '0;
    in_byp     = '0;
    in_v[0]    = valid_i;
    in_byp[0]  = bypass_i;
    in_data[0] = data_i;
    in_k[0]    = shift_i;
    for (int s = 1; s < stages_p; s++) begin
      in_v[s]    = v_q[s-1];
      in_byp[s]  = byp_q[s-1];
      in_data[s] = y_q[s-1];
      in_k[s]    = k_q[s-1];
    end
  end

  assign xfer = in_v & rdy[stages_p-1:0];

  always_comb begin : c_filter
    logic signed [width_p-1:0] samp;
    logic signed [SW-1:0]      x;
    logic signed [SW-1:0]      s_cur;
    logic signed [SW-1:0]      s_nxt;
    logic signed [SW:0]        d;
    v_d   = v_q;
    byp_d = byp_q;
    k_d   = k_q;
    y_d   = y_q;
    st_d  = st_q;
    samp  = '0;
    x     = '0;
    s_cur = '0;
    s_nxt = '0;
    d     = '0;
    for (int s = 0; s < stages_p; s++) begin
      if (xfer[s]) begin
        v_d[s]   = 1'b1;
        byp_d[s] = in_byp[s];
        k_d[s]   = in_k[s];
        for (int c = 0; c < channels_p; c++) begin
          samp  = in_data[s][c*width_p +: width_p];
          x     = SW'(samp) <<< frac_p;
          s_cur = st_q[s][c*SW +: SW];
          d     = {x[SW-1], x} - {s_cur[SW-1], s_cur};
          // Convex step toward x: the sum always fits back into SW bits.
          if (in_byp[s]) begin
            s_nxt = x;
          end else begin
            s_nxt = SW'(s_cur + (d >>> in_k[s]));
          end
          st_d[s][c*SW +: SW]       = s_nxt;
          y_d[s][c*width_p +: width_p] = s_nxt[SW-1 -: width_p];
        end
      end else if (rdy[s+1]) begin
        v_d[s] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q   <= '0;
      byp_q <= '0;
      for (int s = 0; s < stages_p; s++) begin
        k_q[s]  <= '0;
        y_q[s]  <= '0;
        st_q[s] <= '0;
      end
    end else begin
      v_q   <= v_d;
      byp_q <= byp_d;
      k_q   <= k_d;
      y_q   <= y_d;
      st_q  <= st_d;
    end
  end

  assign ready_o = rdy[0];
  assign valid_o = v_q[stages_p-1];
  assign data_o  = y_q[stages_p-1];

endmodule

// File: tb/tb_iir_cascade.sv
// Directed bench for iir_cascade (4 stages, 2x10-bit lanes, 6 fractional bits) with a
// reference-model scoreboard fed on every accepted beat and drained on every output beat.
module tb_iir_cascade;

  localparam int W  = 10;
  localparam int C  = 2;
  localparam int S  = 4;
  localparam int F  = 6;
  localparam int KW = 4;
  localparam int DW = C * W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [KW-1:0] shift;
  logic          bypass;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] data_o;

  always #5 clk = ~clk;

  iir_cascade #(
    .width_p      (W),
    .channels_p   (C),
    .stages_p     (S),
    .frac_p       (F),
    .shift_width_p(KW)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .shift_i  (shift),
    .bypass_i (bypass),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o)
  );

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            acc_cnt, out_cnt, first_acc, first_out, last_out_cyc;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] first_val, last_out, prev_out, hold;
  longint        st[S][C];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(longint a, longint p);
    longint q;
    q = a / p;
    if ((a % p != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint lane(logic [DW-1:0] v, int c);
    logic signed [W-1:0] t;
    t = v[c*W +: W];
    return longint'(t);
  endfunction

  function automatic logic [DW-1:0] pack(int a, int b);
    logic [DW-1:0] r;
    r[W-1:0]  = a[W-1:0];
    r[DW-1:W] = b[W-1:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < S; s++)
      for (int c = 0; c < C; c++) st[s][c] = 0;
  endtask

  // Whole-cascade model: each stage sees beats in order, so the beat is run through all
  // stages at accept time.
  task automatic model_beat(input logic [DW-1:0] din, input int k, input logic byp,
                            output logic [DW-1:0] dout);
    dout = '0;
    for (int c = 0; c < C; c++) begin
      longint v;
      v = lane(din, c);
      for (int s = 0; s < S; s++) begin
        if (byp) begin
          st[s][c] = v * 64;
        end else begin
          st[s][c] = st[s][c] + fdiv(v * 64 - st[s][c], longint'(1) << k);
          v = fdiv(st[s][c], 64);
        end
      end
      dout[c*W +: W] = v[W-1:0];
    end
  endtask

  task automatic clear_stats();
    acc_cnt = 0; out_cnt = 0; first_acc = -1; first_out = -1; last_out_cyc = -1;
  endtask

  task automatic step();
    logic [DW-1:0] e;
    @(negedge clk);
    if (!reset_n) begin
      exp_q.delete();
      model_reset();
    end else begin
      if (valid_o && ready_i) begin
        out_cnt++;
        if (first_out < 0) begin
          first_out = cyc;
          first_val = data_o;
        end
        last_out_cyc = cyc;
        prev_out = last_out;
        last_out = data_o;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ch0", lane(data_o, 0), lane(e, 0));
          chk("sb_ch1", lane(data_o, 1), lane(e, 1));
        end
      end
      if (valid_i && ready_o) begin
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        model_beat(data_i, int'(shift), bypass, e);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid_i = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || valid_o); i++) step();
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; shift = '0; bypass = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
    last_out = '0; prev_out = '0; first_val = '0; hold = '0;
    model_reset();
    clear_stats();
    step();
    do_reset();
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ready", ready_o, 1);

    // Positive step, k=1.
    clear_stats();
    shift = 4'd1; data_i = pack(256, 256); valid_i = 1'b1;
    for (int i = 0; i < 12; i++) step();
    drain();
    chk("step_latency", first_out - first_acc, S);
    chk("step_count", out_cnt, 12);
    chk("step_first", lane(first_val, 0), 16);

    // Negative step with independent lane, then k=0 pass-through of -3.
    do_reset();
    shift = 4'd1; data_i = pack(-256, 100); valid_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    shift = 4'd0; data_i = pack(-3, 7);
    step();
    drain();
    chk("k0_exact_ch0", lane(last_out, 0), -3);
    chk("k0_exact_ch1", lane(last_out, 1), 7);

    // Streaming throughput with k=0.
    clear_stats();
    shift = 4'd0; valid_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      data_i = pack(i, -i);
      step();
    end
    drain();
    chk("stream_count", out_cnt, 20);
    chk("stream_gapless", last_out_cyc - first_out, 19);
    chk("stream_latency", first_out - first_acc, S);
    chk("stream_last", lane(last_out, 0), 20);

    // Backpressure: fill, hold, release.
    clear_stats();
    ready_i = 1'b0; shift = 4'd0; valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_i = pack(30 + acc_cnt, 40 + acc_cnt);
      step();
    end
    chk("bp_accepted", acc_cnt, S);
    chk("bp_ready_low", ready_o, 0);
    chk("bp_valid", valid_o, 1);
    chk("bp_head", lane(data_o, 0), 30);
    hold = data_o;
    data_i = pack(30 + acc_cnt, 40 + acc_cnt);
    step();
    step();
    chk("bp_stable", data_o, hold);
    ready_i = 1'b1;
    #1;
    chk("bp_ready_rise", ready_o, 1);
    step();
    chk("bp_fifth_taken", acc_cnt, S + 1);
    data_i = pack(30 + acc_cnt, 40 + acc_cnt);
    step();
    drain();
    chk("bp_out_total", out_cnt, 6);
    chk("bp_last", lane(last_out, 0), 35);

    // Bypass alignment, k=3.
    do_reset();
    clear_stats();
    shift = 4'd3; bypass = 1'b0; valid_i = 1'b1; data_i = pack(500, 300);
    for (int i = 0; i < 10; i++) step();
    bypass = 1'b1; data_i = pack(-100, -50);
    step();
    bypass = 1'b0;
    step();
    drain();
    chk("byp_beat_ch0", lane(prev_out, 0), -100);
    chk("byp_beat_ch1", lane(prev_out, 1), -50);
    chk("byp_no_transient", lane(last_out, 0), -100);

    // Random mix: mid-stream k/bypass changes, large k, random stalls.
    for (int i = 0; i < 60; i++) begin
      data_i  = pack(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
      shift   = KW'($urandom_range(0, 15));
      bypass  = ($urandom_range(0, 7) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    bypass = 1'b0;
    drain();

    // Reset with beats in flight.
    ready_i = 1'b0; valid_i = 1'b1; shift = 4'd1; data_i = pack(256, 256);
    for (int i = 0; i < 3; i++) step();
    do_reset();
    chk("mr_valid", valid_o, 0);
    chk("mr_data", data_o, 0);
    chk("mr_ready", ready_o, 1);
    ready_i = 1'b1; valid_i = 1'b1; shift = 4'd1; data_i = pack(256, 256);
    step();
    drain();
    chk("mr_first", lane(last_out, 0), 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
